alpha_pipe_razor_recover: RTL and testbench



---
 rtl/alpha_pipe_razor_recover.sv | 152 +++++++++++++++
 tb/tb_alpha_pipe_razor_recover.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alpha_pipe_razor_recover.sv
// Forward-metric (alpha) recursion for the 8-state duo-binary trellis, with
// shadow-flop timing-error detection on the metric MSBs and one-cycle recovery.
module alpha_pipe_razor_recover #(
  parameter int N         = 5,
  parameter int M         = 6,
  parameter int RazorBits = 1,
  parameter int BlockLen  = 64,
  parameter int ErrCntW   = 8,
  parameter int InitMode  = 0
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          Start,
  input  logic                          In_valid,
  output logic                          In_ready,
  input  logic signed [N-1:0]           ba2,
  input  logic signed [M:0]             ba1ba3,
  input  logic signed [M:0]             ba1ba2ba3,
  input  logic        [7*RazorBits-1:0] InjectMask,
  output logic        [7:1][M-1:0]      alpha_out_DFF,
  output logic                          Out_valid,
  output logic                          Done,
  output logic                          Error_current_Alpha,
  output logic        [ErrCntW-1:0]     ErrCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } state_e;

  localparam int CntW = $clog2(BlockLen + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(BlockLen - 1);

  localparam logic signed [M+2:0] SatMax = (M+3)'((1 << (M-1)) - 1);
  localparam logic signed [M+2:0] SatMin = ~SatMax;
  localparam logic        [M-1:0] MetricMin = {1'b1, {(M-1){1'b0}}};

  state_e                    state_q;
  logic [7:1][M-1:0]         alpha_q;
  logic [7:1][RazorBits-1:0] shadow_q;
  logic                      valid_q;
  logic [CntW-1:0]           cnt_q;
  logic [ErrCntW-1:0]        err_cnt_q;

  logic [7:1][M-1:0]         alpha_init;
  logic [7:1][M-1:0]         step_d;
  logic [7:1][M-1:0]         main_d;
  logic [7:1][RazorBits-1:0] shadow_d;
  logic                      err;
  logic                      accept;

  function automatic logic signed [M+1:0] smax(input logic signed [M+1:0] x,
                                               input logic signed [M+1:0] y);
    return (x >= y) ? x : y;
  endfunction

  function automatic logic [M-1:0] sat(input logic signed [M+2:0] d);
    if (d > SatMax)      return SatMax[M-1:0];
    else if (d < SatMin) return SatMin[M-1:0];
    else                 return d[M-1:0];
  endfunction

  assign alpha_init = (InitMode != 0) ? {7{MetricMin}} : '0;

  // A mismatch between any main razor field and its shadow flags a timing error.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    err = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      if (alpha_q[i][M-1 -: RazorBits] != shadow_q[i]) err = 1'b1;
    end
  end

  assign In_ready            = (state_q == RUN) && !err;
  assign accept              = In_valid && In_ready;
  assign Error_current_Alpha = err;
  assign Out_valid           = valid_q && !err;
  assign Done                = (state_q == LAST) && !err;
  assign alpha_out_DFF       = alpha_q;
  assign ErrCount            = err_cnt_q;

  always_comb begin
    logic signed [M+1:0] a [1:7];
    logic signed [M+1:0] n [0:7];
    logic signed [M+1:0] g2, g13, g3;
    logic signed [M+2:0] diff;

    for (int i = 1; i <= 7; i++) a[i] = (M+2)'($signed(alpha_q[i]));
    g2  = (M+2)'(ba2);
    g13 = (M+2)'(ba1ba3);
    g3  = (M+2)'(ba1ba2ba3);

    n[0] = smax('0, a[1] + g3);
    n[1] = smax(a[2] + g13, a[3] + g2);
    n[2] = smax(a[4] + g2,  a[5] + g13);
    n[3] = smax(a[7],       a[6] + g3);
    n[4] = smax(g3,         a[1]);
    n[5] = smax(a[2] + g2,  a[3] + g13);
    n[6] = smax(a[4] + g13, a[5] + g2);
    n[7] = smax(a[6],       a[7] + g3);

    step_d   = '0;
    main_d   = '0;
    shadow_d = '0;
    diff     = '0;
    // Normalise against state 0 so alpha0 stays implicitly zero.
    for (int i = 1; i <= 7; i++) begin
      diff        = (M+3)'(n[i]) - (M+3)'(n[0]);
      step_d[i]   = sat(diff);
      shadow_d[i] = step_d[i][M-1 -: RazorBits];
      main_d[i]   = step_d[i];
      main_d[i][M-1 -: RazorBits] = step_d[i][M-1 -: RazorBits]
                                    ^ InjectMask[(i-1)*RazorBits +: RazorBits];
    end
  end

  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (Reset) begin
      state_q   <= IDLE;
      alpha_q   <= '0;
      shadow_q  <= '0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
      err_cnt_q <= '0;
    end else if (Start) begin
      state_q   <= RUN;
      alpha_q   <= alpha_init;
      for (int i = 1; i <= 7; i++) shadow_q[i] <= alpha_init[i][M-1 -: RazorBits];
      valid_q   <= 1'b0;
      cnt_q     <= '0;
      err_cnt_q <= '0;
    end else if (err) begin
      // Recovery: restore razor bits from the shadow, hold everything else.
      for (int i = 1; i <= 7; i++) alpha_q[i][M-1 -: RazorBits] <= shadow_q[i];
      valid_q <= 1'b1;
      if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
    end else if (accept) begin
      alpha_q  <= main_d;
      shadow_q <= shadow_d;
      valid_q  <= 1'b1;
      cnt_q    <= cnt_q + 1'b1;
      if (cnt_q == LastCnt) state_q <= LAST;
    end else begin
      valid_q <= 1'b0;
      if (state_q == LAST) state_q <= IDLE;
    end
  end

endmodule

// File: tb/tb_alpha_pipe_razor_recover.sv
// Directed bench: two instances (equiprobable and known-state init), BlockLen=4,
// checking arithmetic, saturation, razor recovery, framing and restart behaviour.
module tb_alpha_pipe_razor_recover;

  logic              Clock = 1'b0;
  logic              Reset, Start, In_valid;
  logic signed [4:0] ba2;
  logic signed [6:0] ba1ba3, ba1ba2ba3;
  logic        [6:0] inj0, inj1;

  logic              rdy0, ov0, done0, err0;
  logic              rdy1, ov1, done1, err1;
  logic [7:1][5:0]   alpha0, alpha1;
  logic [7:0]        ecnt0, ecnt1;

  int checks   = 0;
  int failures = 0;
  int acc      = 0;
  int base;

  alpha_pipe_razor_recover #(
    .N(5), .M(6), .RazorBits(1), .BlockLen(4), .ErrCntW(8), .InitMode(0)
  ) dut0 (
    .Clock(Clock), .Reset(Reset), .Start(Start), .In_valid(In_valid),
    .In_ready(rdy0), .ba2(ba2), .ba1ba3(ba1ba3), .ba1ba2ba3(ba1ba2ba3),
    .InjectMask(inj0), .alpha_out_DFF(alpha0), .Out_valid(ov0), .Done(done0),
    .Error_current_Alpha(err0), .ErrCount(ecnt0)
  );

  alpha_pipe_razor_recover #(
    .N(5), .M(6), .RazorBits(1), .BlockLen(4), .ErrCntW(8), .InitMode(1)
  ) dut1 (
    .Clock(Clock), .Reset(Reset), .Start(Start), .In_valid(In_valid),
    .In_ready(rdy1), .ba2(ba2), .ba1ba3(ba1ba3), .ba1ba2ba3(ba1ba2ba3),
    .InjectMask(inj1), .alpha_out_DFF(alpha1), .Out_valid(ov1), .Done(done1),
    .Error_current_Alpha(err1), .ErrCount(ecnt1)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (!Reset && !Start && In_valid && rdy0) acc++;
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic setg(input int g2, input int g13, input int g3);
    ba2       = 5'(g2);
    ba1ba3    = 7'(g13);
    ba1ba2ba3 = 7'(g3);
  endtask

  function automatic logic [41:0] pk(input int a1, input int a2, input int a3,
                                     input int a4, input int a5, input int a6,
                                     input int a7);
    return {6'(a7), 6'(a6), 6'(a5), 6'(a4), 6'(a3), 6'(a2), 6'(a1)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; In_valid = 1'b0; inj0 = '0; inj1 = '0;
    setg(0, 0, 0);
    tick(); tick();
    check("rst_alpha",  64'(alpha0), 64'(pk(0,0,0,0,0,0,0)));
    check("rst_ready",  64'(rdy0),  64'd0);
    check("rst_ovalid", 64'(ov0),   64'd0);
    check("rst_done",   64'(done0), 64'd0);
    check("rst_err",    64'(err0),  64'd0);
    check("rst_ecnt",   64'(ecnt0), 64'd0);
    Reset = 1'b0;

    // Basic step from both initialisations.
    Start = 1'b1; tick(); Start = 1'b0;
    check("start_ready",  64'(rdy0),   64'd1);
    check("start_ovalid", 64'(ov0),    64'd0);
    check("init1_alpha",  64'(alpha1), 64'(pk(-32,-32,-32,-32,-32,-32,-32)));
    setg(1, 2, 3); In_valid = 1'b1; tick(); In_valid = 1'b0;
    check("step_a_alpha0", 64'(alpha0), 64'(pk(-1,-1,0,0,-1,-1,0)));
    check("step_a_ov0",    64'(ov0),    64'd1);
    check("step_a_alpha1", 64'(alpha1), 64'(pk(-30,-30,-29,3,-30,-30,-29)));
    check("step_a_ov1",    64'(ov1),    64'd1);
    tick();
    check("idle_ov0",    64'(ov0),    64'd0);
    check("idle_alpha0", 64'(alpha0), 64'(pk(-1,-1,0,0,-1,-1,0)));

    // Restart mid-block while In_valid is high: Start wins, block count restarts.
    setg(0, 0, 0); In_valid = 1'b1; Start = 1'b1; tick(); Start = 1'b0;
    base = acc;
    check("restart_alpha0", 64'(alpha0), 64'(pk(0,0,0,0,0,0,0)));
    check("restart_ov0",    64'(ov0),    64'd0);
    tick();
    check("zero_alpha0", 64'(alpha0), 64'(pk(0,0,0,0,0,0,0)));
    check("zero_alpha1", 64'(alpha1), 64'(pk(-32,-32,-32,0,-32,-32,-32)));
    setg(-16, -32, 31); tick();
    check("sat_alpha0", 64'(alpha0), 64'(pk(-32,-32,0,0,-32,-32,0)));
    check("sat_done",   64'(done0),  64'd0);
    setg(5, -3, 7); inj0 = 7'b0000100; tick();
    inj0 = '0; setg(0, 0, 0);
    check("inj_alpha0", 64'(alpha0), 64'(pk(5,5,-32,7,-3,-3,7)));
    check("inj_err",    64'(err0),   64'd1);
    check("inj_ready",  64'(rdy0),   64'd0);
    check("inj_ov",     64'(ov0),    64'd0);
    tick();
    check("rec_alpha0", 64'(alpha0), 64'(pk(5,5,0,7,-3,-3,7)));
    check("rec_err",    64'(err0),   64'd0);
    check("rec_ov",     64'(ov0),    64'd1);
    check("rec_ecnt",   64'(ecnt0),  64'd1);
    check("rec_ready",  64'(rdy0),   64'd1);
    tick(); In_valid = 1'b0;
    check("s4_alpha0", 64'(alpha0), 64'(pk(0,2,2,0,0,2,2)));
    check("s4_ov",     64'(ov0),    64'd1);
    check("s4_done",   64'(done0),  64'd1);
    check("s4_ready",  64'(rdy0),   64'd0);
    check("blk_b_accepts", 64'(acc - base), 64'd4);
    tick();
    check("post_done",  64'(done0), 64'd0);
    check("post_ov",    64'(ov0),   64'd0);
    check("post_ready", 64'(rdy0),  64'd0);

    // Continuous block with an error on the final step: Done slips one cycle.
    setg(0, 0, 0); In_valid = 1'b1; Start = 1'b1; tick(); Start = 1'b0;
    base = acc;
    check("c_ecnt_clr", 64'(ecnt0),  64'd0);
    check("c_alpha0",   64'(alpha0), 64'(pk(0,0,0,0,0,0,0)));
    for (int s = 1; s <= 3; s++) begin
      tick();
      check($sformatf("c_s%0d_ov", s),   64'(ov0),   64'd1);
      check($sformatf("c_s%0d_done", s), 64'(done0), 64'd0);
    end
    inj0 = 7'b0000001; tick(); inj0 = '0;
    check("c_s4_alpha0", 64'(alpha0), 64'(pk(-32,0,0,0,0,0,0)));
    check("c_s4_err",    64'(err0),   64'd1);
    check("c_s4_done",   64'(done0),  64'd0);
    check("c_s4_ov",     64'(ov0),    64'd0);
    tick();
    check("c_rec_alpha0", 64'(alpha0), 64'(pk(0,0,0,0,0,0,0)));
    check("c_rec_done",   64'(done0),  64'd1);
    check("c_rec_ov",     64'(ov0),    64'd1);
    check("c_rec_ecnt",   64'(ecnt0),  64'd1);
    tick();
    check("c_end_done",  64'(done0), 64'd0);
    check("c_end_ready", 64'(rdy0),  64'd0);
    check("c_accepts",   64'(acc - base), 64'd4);
    In_valid = 1'b0;

    // Reset mid-block after a recovered error, then a clean full block.
    Start = 1'b1; tick(); Start = 1'b0;
    setg(1, 2, 3); In_valid = 1'b1; inj0 = 7'b0000001; tick();
    In_valid = 1'b0; inj0 = '0;
    check("d_inj_alpha0", 64'(alpha0), 64'(pk(31,-1,0,0,-1,-1,0)));
    check("d_inj_err",    64'(err0),   64'd1);
    tick();
    check("d_rec_alpha0", 64'(alpha0), 64'(pk(-1,-1,0,0,-1,-1,0)));
    check("d_rec_ecnt",   64'(ecnt0),  64'd1);
    Reset = 1'b1; tick(); Reset = 1'b0;
    check("d_rst_alpha0", 64'(alpha0), 64'(pk(0,0,0,0,0,0,0)));
    check("d_rst_ecnt",   64'(ecnt0),  64'd0);
    check("d_rst_ready",  64'(rdy0),   64'd0);
    check("d_rst_ov",     64'(ov0),    64'd0);
    Start = 1'b1; tick(); Start = 1'b0;
    setg(0, 0, 0); In_valid = 1'b1;
    base = acc;
    for (int s = 1; s <= 3; s++) begin
      tick();
      check($sformatf("d_s%0d_done", s), 64'(done0), 64'd0);
    end
    tick(); In_valid = 1'b0;
    check("d_s4_done", 64'(done0), 64'd1);
    check("d_s4_ov",   64'(ov0),   64'd1);
    tick();
    check("d_end_ready", 64'(rdy0),  64'd0);
    check("d_end_done",  64'(done0), 64'd0);
    check("d_accepts",   64'(acc - base), 64'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
